// File: rtl/aes256_key_expand_pkg.sv
// Shared AES types, constants and helpers.
// Used by the key expander and the cipher core.
package aes_pkg;

  typedef logic [31:0] aes_word_t;

  localparam int AES256_NR = 14;
  localparam int AES256_NK = 8;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic {
    IDLE,
    EMIT
  } ks_state_e;

  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes256_key_expand_if.sv
// Key in / round key out handshake bundle.
// slave = expander side, master = key source and round key sink.
interface aes256_key_expand_if;

  logic [255:0] key;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         rk_valid;
  logic         rk_ready;

  modport slave (
    input  key, key_valid, rk_ready,
    output key_ready, rk, rk_idx, rk_last, rk_valid
  );

  modport master (
    output key, key_valid, rk_ready,
    input  key_ready, rk, rk_idx, rk_last, rk_valid
  );

endinterface

// File: rtl/aes256_key_expand_sbox.sv
// AES forward S-box as a combinational case ROM.
// Shared between SubWord here and SubBytes in the core.
module aes_sbox (
  input  logic [7:0] x_i,
  output logic [7:0] y_o
);

  // Byte substitution lookup.
  always_comb begin
    y_o = 8'h00;
    case (x_i)
      8'h00: y_o = 8'h63; 8'h01: y_o = 8'h7c; 8'h02: y_o = 8'h77; 8'h03: y_o = 8'h7b;
      8'h04: y_o = 8'hf2; 8'h05: y_o = 8'h6b; 8'h06: y_o = 8'h6f; 8'h07: y_o = 8'hc5;
      8'h08: y_o = 8'h30; 8'h09: y_o = 8'h01; 8'h0a: y_o = 8'h67; 8'h0b: y_o = 8'h2b;
      8'h0c: y_o = 8'hfe; 8'h0d: y_o = 8'hd7; 8'h0e: y_o = 8'hab; 8'h0f: y_o = 8'h76;
      8'h10: y_o = 8'hca; 8'h11: y_o = 8'h82; 8'h12: y_o = 8'hc9; 8'h13: y_o = 8'h7d;
      8'h14: y_o = 8'hfa; 8'h15: y_o = 8'h59; 8'h16: y_o = 8'h47; 8'h17: y_o = 8'hf0;
      8'h18: y_o = 8'had; 8'h19: y_o = 8'hd4; 8'h1a: y_o = 8'ha2; 8'h1b: y_o = 8'haf;
      8'h1c: y_o = 8'h9c; 8'h1d: y_o = 8'ha4; 8'h1e: y_o = 8'h72; 8'h1f: y_o = 8'hc0;
      8'h20: y_o = 8'hb7; 8'h21: y_o = 8'hfd; 8'h22: y_o = 8'h93; 8'h23: y_o = 8'h26;
      8'h24: y_o = 8'h36; 8'h25: y_o = 8'h3f; 8'h26: y_o = 8'hf7; 8'h27: y_o = 8'hcc;
      8'h28: y_o = 8'h34; 8'h29: y_o = 8'ha5; 8'h2a: y_o = 8'he5; 8'h2b: y_o = 8'hf1;
      8'h2c: y_o = 8'h71; 8'h2d: y_o = 8'hd8; 8'h2e: y_o = 8'h31; 8'h2f: y_o = 8'h15;
      8'h30: y_o = 8'h04; 8'h31: y_o = 8'hc7; 8'h32: y_o = 8'h23; 8'h33: y_o = 8'hc3;
      8'h34: y_o = 8'h18; 8'h35: y_o = 8'h96; 8'h36: y_o = 8'h05; 8'h37: y_o = 8'h9a;
      8'h38: y_o = 8'h07; 8'h39: y_o = 8'h12; 8'h3a: y_o = 8'h80; 8'h3b: y_o = 8'he2;
      8'h3c: y_o = 8'heb; 8'h3d: y_o = 8'h27; 8'h3e: y_o = 8'hb2; 8'h3f: y_o = 8'h75;
      8'h40: y_o = 8'h09; 8'h41: y_o = 8'h83; 8'h42: y_o = 8'h2c; 8'h43: y_o = 8'h1a;
      8'h44: y_o = 8'h1b; 8'h45: y_o = 8'h6e; 8'h46: y_o = 8'h5a; 8'h47: y_o = 8'ha0;
      8'h48: y_o = 8'h52; 8'h49: y_o = 8'h3b; 8'h4a: y_o = 8'hd6; 8'h4b: y_o = 8'hb3;
      8'h4c: y_o = 8'h29; 8'h4d: y_o = 8'he3; 8'h4e: y_o = 8'h2f; 8'h4f: y_o = 8'h84;
      8'h50: y_o = 8'h53; 8'h51: y_o = 8'hd1; 8'h52: y_o = 8'h00; 8'h53: y_o = 8'hed;
      8'h54: y_o = 8'h20; 8'h55: y_o = 8'hfc; 8'h56: y_o = 8'hb1; 8'h57: y_o = 8'h5b;
      8'h58: y_o = 8'h6a; 8'h59: y_o = 8'hcb; 8'h5a: y_o = 8'hbe; 8'h5b: y_o = 8'h39;
      8'h5c: y_o = 8'h4a; 8'h5d: y_o = 8'h4c; 8'h5e: y_o = 8'h58; 8'h5f: y_o = 8'hcf;
      8'h60: y_o = 8'hd0; 8'h61: y_o = 8'hef; 8'h62: y_o = 8'haa; 8'h63: y_o = 8'hfb;
      8'h64: y_o = 8'h43; 8'h65: y_o = 8'h4d; 8'h66: y_o = 8'h33; 8'h67: y_o = 8'h85;
      8'h68: y_o = 8'h45; 8'h69: y_o = 8'hf9; 8'h6a: y_o = 8'h02; 8'h6b: y_o = 8'h7f;
      8'h6c: y_o = 8'h50; 8'h6d: y_o = 8'h3c; 8'h6e: y_o = 8'h9f; 8'h6f: y_o = 8'ha8;
      8'h70: y_o = 8'h51; 8'h71: y_o = 8'ha3; 8'h72: y_o = 8'h40; 8'h73: y_o = 8'h8f;
      8'h74: y_o = 8'h92; 8'h75: y_o = 8'h9d; 8'h76: y_o = 8'h38; 8'h77: y_o = 8'hf5;
      8'h78: y_o = 8'hbc; 8'h79: y_o = 8'hb6; 8'h7a: y_o = 8'hda; 8'h7b: y_o = 8'h21;
      8'h7c: y_o = 8'h10; 8'h7d: y_o = 8'hff; 8'h7e: y_o = 8'hf3; 8'h7f: y_o = 8'hd2;
      8'h80: y_o = 8'hcd; 8'h81: y_o = 8'h0c; 8'h82: y_o = 8'h13; 8'h83: y_o = 8'hec;
      8'h84: y_o = 8'h5f; 8'h85: y_o = 8'h97; 8'h86: y_o = 8'h44; 8'h87: y_o = 8'h17;
      8'h88: y_o = 8'hc4; 8'h89: y_o = 8'ha7; 8'h8a: y_o = 8'h7e; 8'h8b: y_o = 8'h3d;
      8'h8c: y_o = 8'h64; 8'h8d: y_o = 8'h5d; 8'h8e: y_o = 8'h19; 8'h8f: y_o = 8'h73;
      8'h90: y_o = 8'h60; 8'h91: y_o = 8'h81; 8'h92: y_o = 8'h4f; 8'h93: y_o = 8'hdc;
      8'h94: y_o = 8'h22; 8'h95: y_o = 8'h2a; 8'h96: y_o = 8'h90; 8'h97: y_o = 8'h88;
      8'h98: y_o = 8'h46; 8'h99: y_o = 8'hee; 8'h9a: y_o = 8'hb8; 8'h9b: y_o = 8'h14;
      8'h9c: y_o = 8'hde; 8'h9d: y_o = 8'h5e; 8'h9e: y_o = 8'h0b; 8'h9f: y_o = 8'hdb;
      8'ha0: y_o = 8'he0; 8'ha1: y_o = 8'h32; 8'ha2: y_o = 8'h3a; 8'ha3: y_o = 8'h0a;
      8'ha4: y_o = 8'h49; 8'ha5: y_o = 8'h06; 8'ha6: y_o = 8'h24; 8'ha7: y_o = 8'h5c;
      8'ha8: y_o = 8'hc2; 8'ha9: y_o = 8'hd3; 8'haa: y_o = 8'hac; 8'hab: y_o = 8'h62;
      8'hac: y_o = 8'h91; 8'had: y_o = 8'h95; 8'hae: y_o = 8'he4; 8'haf: y_o = 8'h79;
      8'hb0: y_o = 8'he7; 8'hb1: y_o = 8'hc8; 8'hb2: y_o = 8'h37; 8'hb3: y_o = 8'h6d;
      8'hb4: y_o = 8'h8d; 8'hb5: y_o = 8'hd5; 8'hb6: y_o = 8'h4e; 8'hb7: y_o = 8'ha9;
      8'hb8: y_o = 8'h6c; 8'hb9: y_o = 8'h56; 8'hba: y_o = 8'hf4; 8'hbb: y_o = 8'hea;
      8'hbc: y_o = 8'h65; 8'hbd: y_o = 8'h7a; 8'hbe: y_o = 8'hae; 8'hbf: y_o = 8'h08;
      8'hc0: y_o = 8'hba; 8'hc1: y_o = 8'h78; 8'hc2: y_o = 8'h25; 8'hc3: y_o = 8'h2e;
      8'hc4: y_o = 8'h1c; 8'hc5: y_o = 8'ha6; 8'hc6: y_o = 8'hb4; 8'hc7: y_o = 8'hc6;
      8'hc8: y_o = 8'he8; 8'hc9: y_o = 8'hdd; 8'hca: y_o = 8'h74; 8'hcb: y_o = 8'h1f;
      8'hcc: y_o = 8'h4b; 8'hcd: y_o = 8'hbd; 8'hce: y_o = 8'h8b; 8'hcf: y_o = 8'h8a;
      8'hd0: y_o = 8'h70; 8'hd1: y_o = 8'h3e; 8'hd2: y_o = 8'hb5; 8'hd3: y_o = 8'h66;
      8'hd4: y_o = 8'h48; 8'hd5: y_o = 8'h03; 8'hd6: y_o = 8'hf6; 8'hd7: y_o = 8'h0e;
      8'hd8: y_o = 8'h61; 8'hd9: y_o = 8'h35; 8'hda: y_o = 8'h57; 8'hdb: y_o = 8'hb9;
      8'hdc: y_o = 8'h86; 8'hdd: y_o = 8'hc1; 8'hde: y_o = 8'h1d; 8'hdf: y_o = 8'h9e;
      8'he0: y_o = 8'he1; 8'he1: y_o = 8'hf8; 8'he2: y_o = 8'h98; 8'he3: y_o = 8'h11;
      8'he4: y_o = 8'h69; 8'he5: y_o = 8'hd9; 8'he6: y_o = 8'h8e; 8'he7: y_o = 8'h94;
      8'he8: y_o = 8'h9b; 8'he9: y_o = 8'h1e; 8'hea: y_o = 8'h87; 8'heb: y_o = 8'he9;
      8'hec: y_o = 8'hce; 8'hed: y_o = 8'h55; 8'hee: y_o = 8'h28; 8'hef: y_o = 8'hdf;
      8'hf0: y_o = 8'h8c; 8'hf1: y_o = 8'ha1; 8'hf2: y_o = 8'h89; 8'hf3: y_o = 8'h0d;
      8'hf4: y_o = 8'hbf; 8'hf5: y_o = 8'he6; 8'hf6: y_o = 8'h42; 8'hf7: y_o = 8'h68;
      8'hf8: y_o = 8'h41; 8'hf9: y_o = 8'h99; 8'hfa: y_o = 8'h2d; 8'hfb: y_o = 8'h0f;
      8'hfc: y_o = 8'hb0; 8'hfd: y_o = 8'h54; 8'hfe: y_o = 8'hbb; 8'hff: y_o = 8'h16;
      default: y_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/aes256_key_expand.sv
// AES-256 round key streamer: 8-word sliding window,
// one new group of 4 words per accepted round key.
module aes256_key_expand
  import aes_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  aes256_key_expand_if.slave  bus
);

  ks_state_e  state_q, state_d;
  aes_word_t  win_q [AES256_NK];
  aes_word_t  win_d [AES256_NK];
  logic [3:0] idx_q, idx_d;
  logic [7:0] rcon_q, rcon_d;

  aes_word_t  sub_in;
  aes_word_t  sub_out;
  aes_word_t  t;
  aes_word_t  n [4];
  logic       is_last;

  assign is_last = (idx_q == 4'(AES256_NR));

  // Even steps rotate and add rcon, odd steps only substitute.
  assign sub_in = idx_q[0] ? win_q[7]
                           : {win_q[7][23:0], win_q[7][31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .x_i (sub_in[8*g +: 8]),
      .y_o (sub_out[8*g +: 8])
    );
  end

  assign t = idx_q[0] ? sub_out
                      : sub_out ^ {rcon_q, 24'h0};

  assign n[0] = win_q[0] ^ t;
  assign n[1] = win_q[1] ^ n[0];
  assign n[2] = win_q[2] ^ n[1];
  assign n[3] = win_q[3] ^ n[2];

  // Next state: key load in IDLE, window slide per round key.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rcon_d  = rcon_q;
    for (int j = 0; j < AES256_NK; j++) begin
      win_d[j] = win_q[j];
    end
    unique case (state_q)
      IDLE: begin
        if (bus.key_valid) begin
          state_d = EMIT;
          idx_d   = 4'd0;
          rcon_d  = RCON_INIT;
          for (int j = 0; j < AES256_NK; j++) begin
            win_d[j] = bus.key[255-32*j -: 32];
          end
        end
      end
      EMIT: begin
        if (bus.rk_ready) begin
          if (is_last) begin
            state_d = IDLE;
          end else begin
            for (int j = 0; j < 4; j++) begin
              win_d[j]   = win_q[j+4];
              win_d[j+4] = n[j];
            end
            idx_d = idx_q + 4'd1;
            if (!idx_q[0]) begin
              rcon_d = xtime(rcon_q);
            end
          end
        end
      end
    endcase
  end

  // State and window registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      rcon_q  <= RCON_INIT;
      for (int j = 0; j < AES256_NK; j++) begin
        win_q[j] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rcon_q  <= rcon_d;
      for (int j = 0; j < AES256_NK; j++) begin
        win_q[j] <= win_d[j];
      end
    end
  end

  assign bus.key_ready = (state_q == IDLE);
  assign bus.rk_valid  = (state_q == EMIT);
  assign bus.rk        = {win_q[0], win_q[1],
                          win_q[2], win_q[3]};
  assign bus.rk_idx    = idx_q;
  assign bus.rk_last   = (state_q == EMIT) && is_last;

endmodule
